// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/data arbiter onto one shared cyc/stb/ack memory bus
// Optional stuck-transaction timeout is compiled in when ARB_TIMEOUT_EN is defined.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_ack_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_sel_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic [31:0] d_rdata_o,
    output logic        d_ack_o,
    output logic        err_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    input  logic [31:0] m_rdata_i,
    input  logic        m_ack_i,
    output logic        stallreq_o
);
`ifdef ARB_TIMEOUT_EN
    parameter logic [7:0] TIMEOUT_CYC = 8'd255;
`endif

    typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;        // 1 = last grant went to data port
    logic        m_cyc_q, m_cyc_d;
    logic        m_we_q, m_we_d;
    logic [3:0]  m_sel_q, m_sel_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic        if_ack_q, if_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        err_q, err_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        if_pend, d_pend, timeout;

    // A level request still high during its own ack cycle is already served.
    assign if_pend = if_req_i & ~if_ack_q;
    assign d_pend  = d_req_i & ~d_ack_q;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE)
            cnt_d = 8'd0;
        else if (!m_ack_i)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 8'd0;
        else     cnt_q <= cnt_d;
    end

    assign timeout = (state_q != IDLE) && !m_ack_i && ((cnt_q + 8'd1) == TIMEOUT_CYC);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        m_cyc_d   = m_cyc_q;
        m_we_d    = m_we_q;
        m_sel_d   = m_sel_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        if_ack_d  = 1'b0;
        d_ack_d   = 1'b0;
        err_d     = 1'b0;
        if_data_d = if_data_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (d_pend && (!if_pend || !last_q)) begin
                    state_d   = D_BUSY;
                    last_d    = 1'b1;
                    m_cyc_d   = 1'b1;
                    m_we_d    = d_we_i;
                    m_sel_d   = d_sel_i;
                    m_addr_d  = d_addr_i;
                    m_wdata_d = d_wdata_i;
                end else if (if_pend) begin
                    state_d   = IF_BUSY;
                    last_d    = 1'b0;
                    m_cyc_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_sel_d   = 4'hF;
                    m_addr_d  = if_addr_i;
                    m_wdata_d = 32'd0;
                end
            end
            IF_BUSY, D_BUSY: begin
                if (m_ack_i || timeout) begin
                    state_d = IDLE;
                    m_cyc_d = 1'b0;
                    err_d   = ~m_ack_i;
                    if (state_q == IF_BUSY) begin
                        if_ack_d  = 1'b1;
                        if_data_d = m_ack_i ? m_rdata_i : 32'd0;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = m_ack_i ? m_rdata_i : 32'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b0;
            m_cyc_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_sel_q   <= 4'd0;
            m_addr_q  <= 32'd0;
            m_wdata_q <= 32'd0;
            if_ack_q  <= 1'b0;
            d_ack_q   <= 1'b0;
            err_q     <= 1'b0;
            if_data_q <= 32'd0;
            d_rdata_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            m_cyc_q   <= m_cyc_d;
            m_we_q    <= m_we_d;
            m_sel_q   <= m_sel_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            if_ack_q  <= if_ack_d;
            d_ack_q   <= d_ack_d;
            err_q     <= err_d;
            if_data_q <= if_data_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign m_cyc_o    = m_cyc_q;
    assign m_stb_o    = m_cyc_q;
    assign m_we_o     = m_we_q;
    assign m_sel_o    = m_sel_q;
    assign m_addr_o   = m_addr_q;
    assign m_wdata_o  = m_wdata_q;
    assign if_ack_o   = if_ack_q;
    assign d_ack_o    = d_ack_q;
    assign err_o      = err_q;
    assign if_data_o  = if_data_q;
    assign d_rdata_o  = d_rdata_q;
    assign stallreq_o = (if_req_i & ~if_ack_q) | (d_req_i & ~d_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
// Build with ARB_TIMEOUT_EN defined to also exercise the timeout path.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i, d_req_i, d_we_i, m_ack_i;
    logic [31:0] if_addr_i, d_addr_i, d_wdata_i, m_rdata_i;
    logic [3:0]  d_sel_i;
    logic [31:0] if_data_o, d_rdata_o, m_addr_o, m_wdata_o;
    logic        if_ack_o, d_ack_o, err_o, m_cyc_o, m_stb_o, m_we_o, stallreq_o;
    logic [3:0]  m_sel_o;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ws = 0;
    int   stb_cnt = 0;
    bit   mem_ack_en = 1'b1;

    always #5 clk = ~clk;

`ifdef ARB_TIMEOUT_EN
    mem_arbiter #(.TIMEOUT_CYC(8'd4)) dut (
`else
    mem_arbiter dut (
`endif
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o), .err_o(err_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
        .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o), .m_rdata_i(m_rdata_i), .m_ack_i(m_ack_i),
        .stallreq_o(stallreq_o)
    );

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h100) ? 32'h3C01_0001 : (a ^ 32'h5A5A_5A5A);
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit is_d, input logic [31:0] data, input bit err);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input bit is_d);
        int n = 0;
        while (!(is_d ? d_ack_o : if_ack_o) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk1("ack_within_budget", n < 20, 1'b1);
    endtask

    // Memory model: acks after ws wait states while enabled.
    always @(negedge clk) begin
        if (m_stb_o && mem_ack_en && stb_cnt == ws) begin
            m_ack_i   = 1'b1;
            m_rdata_i = mem_val(m_addr_o);
        end else begin
            m_ack_i = 1'b0;
        end
        stb_cnt = m_stb_o ? stb_cnt + 1 : 0;
    end

    // Completion monitor against the scoreboard.
    always @(negedge clk) begin
        if (!rst && (if_ack_o || d_ack_o)) begin
            exp_t e;
            chk1("ack_onehot", if_ack_o & d_ack_o, 1'b0);
            chk1("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk1("ack_port", d_ack_o, e.is_d);
                chk32("ack_data", d_ack_o ? d_rdata_o : if_data_o, e.data);
                chk1("ack_err", err_o, e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        if_req_i = 1'b0; if_addr_i = '0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_sel_i = '0; d_addr_i = '0; d_wdata_i = '0;
        m_ack_i = 1'b0; m_rdata_i = '0;
        repeat (2) @(negedge clk);
        chk1("rst_cyc", m_cyc_o, 1'b0);
        chk1("rst_stb", m_stb_o, 1'b0);
        chk32("rst_addr", m_addr_o, 32'd0);
        chk1("rst_acks", if_ack_o | d_ack_o | err_o, 1'b0);
        chk32("rst_ifdata", if_data_o, 32'd0);
        chk32("rst_drdata", d_rdata_o, 32'd0);
        chk1("rst_stall", stallreq_o, 1'b0);
        rst = 1'b0;

        // Fetch only, zero-wait memory
        @(negedge clk);
        if_addr_i = 32'h100; if_req_i = 1'b1;
        push(1'b0, 32'h3C01_0001, 1'b0);
        @(negedge clk);
        chk1("f_stb", m_stb_o, 1'b1);
        chk1("f_cyc", m_cyc_o, 1'b1);
        chk32("f_addr", m_addr_o, 32'h100);
        chk32("f_sel", 32'(m_sel_o), 32'hF);
        chk1("f_we", m_we_o, 1'b0);
        chk32("f_wdata", m_wdata_o, 32'd0);
        chk1("f_stall", stallreq_o, 1'b1);
        @(negedge clk);
        chk1("f_ack_latency", if_ack_o, 1'b1);
        if_req_i = 1'b0;
        @(negedge clk);
        chk1("f_ack_width", if_ack_o, 1'b0);
        chk32("f_data_hold", if_data_o, 32'h3C01_0001);
        chk1("f_stb_drop", m_stb_o, 1'b0);

        // Data write
        d_addr_i = 32'h2000; d_we_i = 1'b1; d_sel_i = 4'b0011; d_wdata_i = 32'hDEAD_BEEF;
        d_req_i = 1'b1;
        push(1'b1, mem_val(32'h2000), 1'b0);
        @(negedge clk);
        chk1("w_we", m_we_o, 1'b1);
        chk32("w_sel", 32'(m_sel_o), 32'h3);
        chk32("w_wdata", m_wdata_o, 32'hDEAD_BEEF);
        chk32("w_addr", m_addr_o, 32'h2000);
        wait_ack(1'b1);
        chk1("w_if_quiet", if_ack_o, 1'b0);
        d_req_i = 1'b0; d_we_i = 1'b0;
        @(negedge clk);
        chk1("w_ack_width", d_ack_o, 1'b0);

        // Both requesting continuously from reset: D, IF, D, IF
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        d_addr_i = 32'h800; d_sel_i = 4'hF; if_addr_i = 32'h400;
        d_req_i = 1'b1; if_req_i = 1'b1;
        push(1'b1, mem_val(32'h800), 1'b0);
        push(1'b0, mem_val(32'h400), 1'b0);
        push(1'b1, mem_val(32'h800), 1'b0);
        push(1'b0, mem_val(32'h400), 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("rr_stb", m_stb_o, 1'b1);
            chk32("rr_addr", m_addr_o, (i % 2 == 0) ? 32'h800 : 32'h400);
            chk1("rr_no_ack_in_stb", if_ack_o | d_ack_o, 1'b0);
            @(negedge clk);
            chk1("rr_d_ack", d_ack_o, i % 2 == 0);
            chk1("rr_if_ack", if_ack_o, i % 2 == 1);
        end
        d_req_i = 1'b0; if_req_i = 1'b0;

        // Three wait states
        ws = 3;
        @(negedge clk);
        d_addr_i = 32'h3000; d_req_i = 1'b1;
        push(1'b1, mem_val(32'h3000), 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("ws_stb", m_stb_o, 1'b1);
            chk32("ws_addr", m_addr_o, 32'h3000);
            chk1("ws_stall", stallreq_o, 1'b1);
            chk1("ws_no_ack", d_ack_o, 1'b0);
        end
        @(negedge clk);
        chk1("ws_ack", d_ack_o, 1'b1);
        chk1("ws_stall_release", stallreq_o, 1'b0);
        d_req_i = 1'b0;
        ws = 0;

        // Reset during D_BUSY
        @(negedge clk);
        mem_ack_en = 1'b0;
        d_addr_i = 32'h4000; d_we_i = 1'b1; d_wdata_i = 32'h1234_5678; d_req_i = 1'b1;
        @(negedge clk);
        chk1("rb_stb", m_stb_o, 1'b1);
        rst = 1'b1;
        #1;
        chk1("rb_async_stb", m_stb_o, 1'b0);
        chk32("rb_async_addr", m_addr_o, 32'd0);
        chk32("rb_async_wdata", m_wdata_o, 32'd0);
        chk1("rb_async_we", m_we_o, 1'b0);
        chk32("rb_async_drdata", d_rdata_o, 32'd0);
        chk32("rb_async_ifdata", if_data_o, 32'd0);
        chk1("rb_async_acks", if_ack_o | d_ack_o | err_o, 1'b0);
        d_req_i = 1'b0; d_we_i = 1'b0;
        if_addr_i = 32'h500; if_req_i = 1'b1;
        push(1'b0, mem_val(32'h500), 1'b0);
        mem_ack_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_ack(1'b0);
        chk1("rb_no_d_ack", d_ack_o, 1'b0);
        if_req_i = 1'b0;

`ifdef ARB_TIMEOUT_EN
        // Memory never acks: timeout after 4 busy cycles
        @(negedge clk);
        mem_ack_en = 1'b0;
        d_addr_i = 32'h6000; d_req_i = 1'b1;
        push(1'b1, 32'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("to_stb", m_stb_o, 1'b1);
            chk1("to_no_ack", d_ack_o, 1'b0);
        end
        @(negedge clk);
        chk1("to_ack", d_ack_o, 1'b1);
        chk1("to_err", err_o, 1'b1);
        d_req_i = 1'b0;
        mem_ack_en = 1'b1;
        @(negedge clk);
        if_addr_i = 32'h700; if_req_i = 1'b1;
        push(1'b0, mem_val(32'h700), 1'b0);
        wait_ack(1'b0);
        chk1("to_next_err", err_o, 1'b0);
        if_req_i = 1'b0;
`endif

        repeat (3) @(negedge clk);
        chk1("sb_drained", sb.size() == 0, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
